uart_cmd_parser: RTL
====================

Name: uart_cmd_parser

Overview:
- Framed command decoder directly downstream of the UART byte receiver (UART_ReadD) on the Bluetooth link.
- Replaces ad-hoc single-byte command matching with a 4-byte packet: header, cmd, arg, XOR checksum.
- Validated packets drive the buzzer enable and are also exported as a one-cycle command strobe for other consumers.
- Tracks checksum and inter-byte timeout errors for reporting in the status frame.

Parameters:
- HEADER, 8'hA5, packet start byte.
- TIMEOUT_CYCLES, 1000000, max Clock cycles between bytes inside a packet (10 ms at 100 MHz); must be ≥2.
- ERR_W, 8, width of each error counter.

Ports:
- Clock  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- arrived  input  1  one-cycle strobe from UART receiver; data is valid in the same cycle.
- data  input  8  received byte.
- cmd_valid  output  1  one-cycle strobe; a packet passed its checksum.
- cmd  output  8  command byte of the last valid packet; held until the next valid packet.
- arg  output  8  argument byte of the last valid packet; held until the next valid packet.
- buzz_en  output  1  buzzer enable, 1 = sounding.
- busy  output  1  high whenever the FSM is not in IDLE.
- chk_err_cnt  output  ERR_W  saturating count of checksum failures.
- tmo_err_cnt  output  ERR_W  saturating count of inter-byte timeouts.

Behaviour:
- Reset values (synchronous, Reset sampled high on a rising edge):
  - FSM = IDLE, cmd_valid = 0, cmd = 0, arg = 0.
  - buzz_en = 1, matching the existing power-on buzzer state.
  - both error counters = 0, timer = 0.
  - Reset overrides every other event, including a packet in progress.
- FSM states: IDLE, GOT_HDR, GOT_CMD, GOT_ARG. Bytes are only consumed in cycles where arrived = 1.
  - IDLE: byte == HEADER → GOT_HDR. Any other byte is discarded silently; no counter changes.
  - GOT_HDR: latch byte into cmd_sh → GOT_CMD. A HEADER value here is treated as a command byte; there is no resync.
  - GOT_CMD: latch byte into arg_sh → GOT_ARG.
  - GOT_ARG: compare byte against HEADER ^ cmd_sh ^ arg_sh, then always → IDLE.
    - Match: on the next edge cmd <= cmd_sh, arg <= arg_sh, cmd_valid = 1 for exactly one cycle.
    - Mismatch: chk_err_cnt increments; cmd, arg and buzz_en are unchanged; no strobe.
- Latency: cmd_valid rises on the first rising edge after the checksum byte's arrived cycle (1 cycle).
- buzz_en update on a valid packet, registered in the same edge as cmd_valid:
  - cmd 8'h88 → 0.
  - cmd 8'h99 → 1.
  - any other cmd leaves buzz_en unchanged; arg is ignored for buzz_en.
- Timer:
  - Cleared to 0 on every arrived and whenever the FSM is in IDLE; otherwise increments each cycle.
  - When the timer reaches TIMEOUT_CYCLES-1 with arrived = 0 and the FSM not in IDLE: FSM → IDLE, tmo_err_cnt increments, partial packet discarded, no strobe.
  - If arrived coincides with that expiry cycle, the byte is processed normally and no timeout is counted.
- Counters saturate at all-ones and never wrap. The two counters are independent and have no clear input other than Reset.
- busy is purely combinational from the FSM state register.
- Back-to-back packets with arrived in consecutive cycles are accepted. A header arriving in the cycle after the checksum byte is accepted, since the FSM is already back in IDLE.

Test Plan:
- Reset, send A5 88 00 2D, one byte every 10 cycles → cmd_valid pulses once, 1 cycle after the 2D byte; cmd = 88, arg = 00; buzz_en 1→0; both counters = 0.
- Send A5 99 00 3C then A5 42 17 F0 → buzz_en returns to 1; second packet strobes with cmd = 42, arg = 17; buzz_en stays 1.
- Send A5 88 00 2C (bad checksum) → no strobe; buzz_en unchanged; chk_err_cnt = 1; busy = 0 afterwards.
- Send 00 FF A5 88, then stall TIMEOUT_CYCLES (use a 16-cycle parameter override) → leading junk ignored; FSM → IDLE; tmo_err_cnt = 1. A following full valid packet is accepted.
- Timeout edge: third byte lands on the expiry cycle → no timeout counted; packet completes normally. Also assert Reset mid-packet → all outputs return to reset values; the next packet decodes correctly.
- Force 300 bad packets with ERR_W = 8 → chk_err_cnt saturates at FF and does not wrap.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Framed command decoder behind the UART byte receiver.
// Accepts HEADER/cmd/arg/XOR-checksum packets and drives the buzzer enable and error counters.
module uart_cmd_parser #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         ERR_W          = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             arrived,
  input  logic [7:0]       data,
  output logic             cmd_valid,
  output logic [7:0]       cmd,
  output logic [7:0]       arg,
  output logic             buzz_en,
  output logic             busy,
  output logic [ERR_W-1:0] chk_err_cnt,
  output logic [ERR_W-1:0] tmo_err_cnt
);

  localparam int                TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        CMD_OFF  = 8'h88;
  localparam logic [7:0]        CMD_ON   = 8'h99;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GOT_HDR = 2'd1,
    ST_GOT_CMD = 2'd2,
    ST_GOT_ARG = 2'd3
  } state_t;

  state_t             state_r;
  logic [TMR_W-1:0]   timer_r;
  logic [7:0]         cmd_sh_r;
  logic [7:0]         arg_sh_r;
  logic               cmd_valid_r;
  logic [7:0]         cmd_r;
  logic [7:0]         arg_r;
  logic               buzz_en_r;
  logic [ERR_W-1:0]   chk_err_cnt_r;
  logic [ERR_W-1:0]   tmo_err_cnt_r;
  logic               timeout_s;
  logic               chk_ok_s;

  function automatic logic [7:0] packet_chk(input logic [7:0] hdr,
                                            input logic [7:0] c,
                                            input logic [7:0] a);
    return hdr ^ c ^ a;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (v == {ERR_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(ERR_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // Expiry and checksum qualifiers for the current cycle
  always_comb begin
    timeout_s = 1'b0;
    chk_ok_s  = 1'b0;
    if ((state_r != ST_IDLE) && !arrived && (timer_r == TMR_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
    if (data == packet_chk(HEADER, cmd_sh_r, arg_sh_r)) begin
      chk_ok_s = 1'b1;
    end else begin
      chk_ok_s = 1'b0;
    end
  end

  // Packet FSM, inter-byte timer, decoded outputs and error counters
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r       <= ST_IDLE;
      timer_r       <= '0;
      cmd_sh_r      <= 8'h00;
      arg_sh_r      <= 8'h00;
      cmd_valid_r   <= 1'b0;
      cmd_r         <= 8'h00;
      arg_r         <= 8'h00;
      buzz_en_r     <= 1'b1;
      chk_err_cnt_r <= '0;
      tmo_err_cnt_r <= '0;
    end else begin
      cmd_valid_r <= 1'b0;

      // An arriving byte always wins over an expiry in the same cycle
      if (arrived || (state_r == ST_IDLE) || timeout_s) begin
        timer_r <= '0;
      end else begin
        timer_r <= timer_r + TMR_W'(1);
      end

      case (state_r)
        ST_IDLE: begin
          if (arrived && (data == HEADER)) begin
            state_r <= ST_GOT_HDR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GOT_HDR: begin
          if (arrived) begin
            cmd_sh_r <= data;
            state_r  <= ST_GOT_CMD;
          end else if (timeout_s) begin
            state_r       <= ST_IDLE;
            tmo_err_cnt_r <= sat_inc(tmo_err_cnt_r);
          end else begin
            state_r <= ST_GOT_HDR;
          end
        end
        ST_GOT_CMD: begin
          if (arrived) begin
            arg_sh_r <= data;
            state_r  <= ST_GOT_ARG;
          end else if (timeout_s) begin
            state_r       <= ST_IDLE;
            tmo_err_cnt_r <= sat_inc(tmo_err_cnt_r);
          end else begin
            state_r <= ST_GOT_CMD;
          end
        end
        ST_GOT_ARG: begin
          if (arrived) begin
            state_r <= ST_IDLE;
            if (chk_ok_s) begin
              cmd_r       <= cmd_sh_r;
              arg_r       <= arg_sh_r;
              cmd_valid_r <= 1'b1;
              case (cmd_sh_r)
                CMD_OFF: buzz_en_r <= 1'b0;
                CMD_ON:  buzz_en_r <= 1'b1;
                default: buzz_en_r <= buzz_en_r;
              endcase
            end else begin
              chk_err_cnt_r <= sat_inc(chk_err_cnt_r);
            end
          end else if (timeout_s) begin
            state_r       <= ST_IDLE;
            tmo_err_cnt_r <= sat_inc(tmo_err_cnt_r);
          end else begin
            state_r <= ST_GOT_ARG;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_r;
  assign cmd         = cmd_r;
  assign arg         = arg_r;
  assign buzz_en     = buzz_en_r;
  assign chk_err_cnt = chk_err_cnt_r;
  assign tmo_err_cnt = tmo_err_cnt_r;
  assign busy        = (state_r != ST_IDLE);

endmodule
